// File: rtl/sseg_scan_decoder_if.sv
// Bundle of the multiplexed display bus seen by the scan decoder: the raw
// anode/segment lines and the decoded results.
interface sseg_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] bin;
  logic [3:0]  err;
  logic        frame_tick;

  // Display driver side: drives the lines, observes the decoded value.
  modport master (
    output an, sseg,
    input  bin, err, frame_tick
  );

  // Decoder side: samples the lines, produces the decoded value.
  modport slave (
    input  an, sseg,
    output bin, err, frame_tick
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Seven-segment scan decoder: watches a 4-digit multiplexed, active-low
// display bus, debounces each anode/segment pair and turns stable digits
// back into a 16-bit hex value with per-digit error flags and a frame tick.
module sseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic [3:0]  iAN,
  input  logic [6:0]  iSSEG,
  output logic [15:0] oBIN,
  output logic [3:0]  oERR,
  output logic        oFRAME_TICK
);

  localparam logic [7:0]  CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [10:0] ALL_OFF  = {4'hF, 7'h7F};

  logic [10:0] sample_in;
  logic [10:0] sample_q;
  logic [7:0]  cnt_q;
  logic [3:0]  mask_q;
  logic [3:0]  mask_set;
  logic        same;
  logic        digit_ok;
  logic [1:0]  digit_idx;
  logic        seg_ok;
  logic [3:0]  nibble;
  logic        capture;

  // Select the digit, decode the segment pattern and decide whether to capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sample_in = {iAN, iSSEG};
    same      = (sample_in == sample_q);
    digit_ok  = 1'b1;
    digit_idx = 2'd0;
    seg_ok    = 1'b1;
    nibble    = 4'h0;

    case (iAN)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: digit_ok  = 1'b0;
    endcase

    case (iSSEG)
      7'h40:   nibble = 4'h0;
      7'h79:   nibble = 4'h1;
      7'h24:   nibble = 4'h2;
      7'h30:   nibble = 4'h3;
      7'h19:   nibble = 4'h4;
      7'h12:   nibble = 4'h5;
      7'h02:   nibble = 4'h6;
      7'h78:   nibble = 4'h7;
      7'h00:   nibble = 4'h8;
      7'h10:   nibble = 4'h9;
      7'h08:   nibble = 4'hA;
      7'h03:   nibble = 4'hB;
      7'h46:   nibble = 4'hC;
      7'h21:   nibble = 4'hD;
      7'h06:   nibble = 4'hE;
      7'h0E:   nibble = 4'hF;
      default: seg_ok = 1'b0;
    endcase

    // The counter saturates one past the capture point, so a held pair
    // matches CNT_LAST exactly once.
    capture  = same && (cnt_q == CNT_LAST) && digit_ok;
    mask_set = mask_q | (4'b0001 << digit_idx);
  end

  // Sample register and saturating stability counter.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      sample_q <= ALL_OFF;
      cnt_q    <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      sample_q <= sample_in;
      if (!same)
        cnt_q <= 8'd0;
      else if (cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  // Capture into the output value/error flags and track frame completion.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      oBIN        <= 16'h0000;
      oERR        <= 4'h0;
      oFRAME_TICK <= 1'b0;
      mask_q      <= 4'h0;
    end else begin
      oFRAME_TICK <= 1'b0;
      if (capture) begin
        if (seg_ok) begin
          oBIN[{digit_idx, 2'b00} +: 4] <= nibble;
          oERR[digit_idx]               <= 1'b0;
        end else begin
          oERR[digit_idx] <= 1'b1;
        end
        if (mask_set == 4'hF) begin
          mask_q      <= 4'h0;
          oFRAME_TICK <= 1'b1;
        end else begin
          mask_q <= mask_set;
        end
      end
    end
  end

endmodule
